instr_encoder: RTL

// - Packs one instruction request into the 32-bit word stream that the instruction decoder consumes.
// - Emits the optional I prefix (immhi) and T prefix (targets 3/4) ahead of the main D/W word.
// - Emits fragment start/end words.
// - Sits between the scheduler/assembler front end and instruction memory or the fetch FIFO.
// - Valid/ready handshake on both sides.

---
 rtl/instr_encoder_if.sv | 51 +++++
 rtl/instr_encoder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_if.sv
// ============================================================================
// Module   : instr_encoder_if
// Purpose  : Request and encoded-word stream bundle for instr_encoder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface instr_encoder_if;
    // Request side
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [3:0]  in_funct;
    logic        in_immab;
    logic [31:0] in_imm;
    logic [2:0]  in_ntgt;
    logic [5:0]  in_ta1;
    logic [5:0]  in_ta2;
    logic [5:0]  in_ta3;
    logic [5:0]  in_ta4;
    logic [1:0]  in_tt1;
    logic [1:0]  in_tt2;
    logic [1:0]  in_tt3;
    logic [1:0]  in_tt4;
    logic [9:0]  in_offset;
    logic [5:0]  in_nalloc;
    logic        in_endf;

    // Word stream side
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_first;
    logic        out_last;

    modport master (
        output in_valid, in_op, in_funct, in_immab, in_imm, in_ntgt,
               in_ta1, in_ta2, in_ta3, in_ta4, in_tt1, in_tt2, in_tt3, in_tt4,
               in_offset, in_nalloc, in_endf, out_ready,
        input  in_ready, out_valid, out_word, out_first, out_last
    );

    modport slave (
        input  in_valid, in_op, in_funct, in_immab, in_imm, in_ntgt,
               in_ta1, in_ta2, in_ta3, in_ta4, in_tt1, in_tt2, in_tt3, in_tt4,
               in_offset, in_nalloc, in_endf, out_ready,
        output in_ready, out_valid, out_word, out_first, out_last
    );
endinterface

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module   : instr_encoder
// Purpose  : Packs one instruction request into I/T prefix words plus a main
//            D/W/F word for the instruction decoder stream.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_encoder #(
    parameter logic FORCE_IPREFIX = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_encoder_if.slave bus,
    output logic           err,
    output logic [15:0]    word_count
);

    localparam logic [2:0] OP_D0 = 3'b000;
    localparam logic [2:0] OP_D1 = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_T  = 3'b011;
    localparam logic [2:0] OP_I  = 3'b100;
    localparam logic [2:0] OP_F  = 3'b101;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EMIT_I    = 2'd1,
        EMIT_T    = 2'd2,
        EMIT_MAIN = 2'd3
    } state_e;

    state_e      state_q;
    state_e      state_d;

    logic [31:0] i_word_q;
    logic [31:0] t_word_q;
    logic [31:0] main_word_q;
    logic        need_i_q;
    logic        need_t_q;
    logic        err_q;
    logic [15:0] word_count_q;

    logic        accept;
    logic        out_hs;
    logic        is_d;
    logic        is_w;
    logic        is_f;
    logic        illegal;
    logic        need_i;
    logic        need_t;
    logic [7:0]  slot1;
    logic [7:0]  slot2;
    logic [7:0]  slot3;
    logic [7:0]  slot4;
    logic [31:0] d_word;
    logic [31:0] w_word;
    logic [31:0] f_word;
    logic [31:0] t_word;
    logic [31:0] i_word;
    logic [31:0] main_word;

    // ------------------------------------------------------------------
    // Request decode and word formation
    // ------------------------------------------------------------------
    assign is_d    = (bus.in_op == OP_D0) || (bus.in_op == OP_D1);
    assign is_w    = (bus.in_op == OP_W);
    assign is_f    = (bus.in_op == OP_F);
    assign illegal = !(is_d || is_w || is_f) || (is_d && (bus.in_ntgt > 3'd4));
    assign need_i  = (is_d || is_w) && ((|bus.in_imm[31:6]) || FORCE_IPREFIX);
    assign need_t  = is_d && (bus.in_ntgt >= 3'd3);

    // Target slots past the requested count are forced to zero
    assign slot1 = (bus.in_ntgt >= 3'd1) ? {bus.in_tt1, bus.in_ta1} : 8'h00;
    assign slot2 = (bus.in_ntgt >= 3'd2) ? {bus.in_tt2, bus.in_ta2} : 8'h00;
    assign slot3 = (bus.in_ntgt >= 3'd3) ? {bus.in_tt3, bus.in_ta3} : 8'h00;
    assign slot4 = (bus.in_ntgt >= 3'd4) ? {bus.in_tt4, bus.in_ta4} : 8'h00;

    assign d_word = {bus.in_op, bus.in_funct, bus.in_immab, bus.in_imm[5:0],
                     2'b00, slot2, slot1};
    assign w_word = {OP_W, bus.in_funct, bus.in_immab, bus.in_imm[5:0],
                     8'h00, bus.in_offset};
    assign f_word = {OP_F, bus.in_endf, 22'h000000, bus.in_nalloc};
    assign t_word = {OP_T, 13'h0000, slot4, slot3};
    assign i_word = {OP_I, 3'b000, bus.in_imm[31:6]};

    assign main_word = is_f ? f_word : (is_w ? w_word : d_word);

    assign accept = bus.in_valid && (state_q == IDLE);
    assign out_hs = (state_q != IDLE) && bus.out_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and stream outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = 1'b0;
        bus.out_word  = 32'h0000_0000;
        bus.out_first = 1'b0;
        bus.out_last  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept && !illegal) begin
                    if (need_i) begin
                        state_d = EMIT_I;
                    end else if (need_t) begin
                        state_d = EMIT_T;
                    end else begin
                        state_d = EMIT_MAIN;
                    end
                end
            end
            EMIT_I: begin
                bus.out_valid = 1'b1;
                bus.out_word  = i_word_q;
                bus.out_first = 1'b1;
                if (out_hs) begin
                    state_d = need_t_q ? EMIT_T : EMIT_MAIN;
                end
            end
            EMIT_T: begin
                bus.out_valid = 1'b1;
                bus.out_word  = t_word_q;
                bus.out_first = !need_i_q;
                if (out_hs) begin
                    state_d = EMIT_MAIN;
                end
            end
            EMIT_MAIN: begin
                bus.out_valid = 1'b1;
                bus.out_word  = main_word_q;
                bus.out_first = !need_i_q && !need_t_q;
                bus.out_last  = 1'b1;
                if (out_hs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Captured request words, error pulse and word counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_word_q     <= 32'h0000_0000;
            t_word_q     <= 32'h0000_0000;
            main_word_q  <= 32'h0000_0000;
            need_i_q     <= 1'b0;
            need_t_q     <= 1'b0;
            err_q        <= 1'b0;
            word_count_q <= 16'h0000;
        end else begin
            err_q <= accept && illegal;
            if (accept && !illegal) begin
                i_word_q    <= i_word;
                t_word_q    <= t_word;
                main_word_q <= main_word;
                need_i_q    <= need_i;
                need_t_q    <= need_t;
            end
            if (out_hs) begin
                word_count_q <= word_count_q + 16'd1;
            end
        end
    end

    assign err        = err_q;
    assign word_count = word_count_q;

endmodule

`default_nettype wire
